// File: rtl/uart_tx_arbiter_if.sv
// Signal bundle between the UART TX arbiter, its requesters and the TX FIFO write port.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req;
  logic [32*NREQ-1:0] req_data;
  logic [2*NREQ-1:0]  req_len;
  logic [NREQ-1:0]    ack;
  logic               txff;
  logic               fifo_wr;
  logic [7:0]         fifo_wdata;
  logic               busy;
  logic [IDW-1:0]     gnt_id;

  modport master (
    output req, req_data, req_len, txff,
    input  ack, fifo_wr, fifo_wdata, busy, gnt_id
  );

  modport slave (
    input  req, req_data, req_len, txff,
    output ack, fifo_wr, fifo_wdata, busy, gnt_id
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter serialising 32-bit requester words LSB-byte-first into the UART TX FIFO.
// Build option UART_ARB_FIXED_PRIO_EN: lowest-index requester always wins instead of round-robin.
module uart_tx_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PUSH = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [31:0]    shift_q, shift_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [IDW-1:0] gnt_q, gnt_d;
  logic [IDW-1:0] win_id;
  logic [31:0]    win_data;
  logic [1:0]     win_len;
  logic           wr;

`ifdef UART_ARB_FIXED_PRIO_EN
  always_comb begin
    win_id = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req[k]) win_id = IDW'(k);
    end
  end
`else
  logic [IDW-1:0] rr_q, rr_d;
  logic           hi_vld;
  logic [IDW-1:0] hi_id, lo_id;

  // Lowest set bit above rr_q wins; otherwise wrap to the lowest set bit overall.
  always_comb begin
    hi_vld = 1'b0;
    hi_id  = '0;
    lo_id  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req[k]) begin
        lo_id = IDW'(k);
        if (IDW'(k) > rr_q) begin
          hi_vld = 1'b1;
          hi_id  = IDW'(k);
        end
      end
    end
    win_id = hi_vld ? hi_id : lo_id;
  end

  assign rr_d = (state_q == S_DONE) ? gnt_q : rr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_q <= IDW'(NREQ - 1);
    else        rr_q <= rr_d;
  end
`endif

  always_comb begin
    win_data = '0;
    win_len  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (IDW'(k) == win_id) begin
        win_data = bus.req_data[32*k +: 32];
        win_len  = bus.req_len[2*k +: 2];
      end
    end
  end

  assign wr = (state_q == S_PUSH) && !bus.txff;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          state_d = S_PUSH;
          shift_d = win_data;
          cnt_d   = win_len;
          gnt_d   = win_id;
        end
      end
      S_PUSH: begin
        if (wr) begin
          shift_d = {8'h00, shift_q[31:8]};
          if (cnt_q == 2'd0) state_d = S_DONE;
          else               cnt_d   = cnt_q - 2'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Data registers are cleared too so the FIFO byte bus reads zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus.fifo_wr    = wr;
  assign bus.fifo_wdata = shift_q[7:0];
  assign bus.busy       = (state_q == S_PUSH) || (state_q == S_DONE);
  assign bus.gnt_id     = gnt_q;
  assign bus.ack        = (state_q == S_DONE) ? (NREQ'(1) << gnt_q) : '0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected bytes/acks queued at stimulus, popped on DUT output.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic reset;
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   wr_cnt  = 0;
  logic [7:0] exp_b[$];
  int         exp_a[$];

  uart_tx_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, want, $time);
    end
  endtask

  // Output monitor: every FIFO write and every ack is matched against the scoreboard.
  always @(negedge clk) begin
    int id;
    if (reset) begin
      if (bus.fifo_wr) begin
        wr_cnt++;
        chk("wr_in_busy", 32'(bus.busy), 1);
        chk("wr_expected", 32'(exp_b.size() > 0), 1);
        if (exp_b.size() > 0) chk("wr_byte", 32'(bus.fifo_wdata), 32'(exp_b.pop_front()));
      end
      if (bus.ack != '0) begin
        chk("ack_expected", 32'(exp_a.size() > 0), 1);
        if (exp_a.size() > 0) begin
          id = exp_a.pop_front();
          chk("ack_onehot", 32'(bus.ack), 32'(1) << id);
          chk("ack_gnt_id", 32'(bus.gnt_id), 32'(id));
        end
      end
    end
  end

  task automatic post(input int id, input logic [31:0] data, input logic [1:0] len);
    bus.req_data[32*id +: 32] = data;
    bus.req_len[2*id +: 2]    = len;
    bus.req[id]               = 1'b1;
  endtask

  task automatic expect_word(input int id, input logic [31:0] data, input logic [1:0] len);
    for (int b = 0; b <= int'(len); b++) exp_b.push_back(data[8*b +: 8]);
    exp_a.push_back(id);
  endtask

  task automatic wait_ack(input int id, input bit drop, output int at);
    bit seen = 1'b0;
    at = -1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.ack[id]) begin
        seen = 1'b1;
        at   = cyc;
        if (drop) bus.req[id] = 1'b0;
      end
    end
    chk("ack_seen", 32'(seen), 1);
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    bus.req  = '0;
    bus.txff = 1'b0;
    exp_b.delete();
    exp_a.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, a0, a1, base, w0, id;
    reset        = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    bus.req_len  = '0;
    bus.txff     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fifo_wr", 32'(bus.fifo_wr), 0);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_gnt_id", 32'(bus.gnt_id), 0);
    chk("rst_wdata", 32'(bus.fifo_wdata), 0);
    reset = 1'b1;

    // Single 4-byte word from requester 0
    @(posedge clk); #1;
    c0 = cyc; base = wr_cnt;
    post(0, 32'hA1B2C3D4, 2'd3);
    expect_word(0, 32'hA1B2C3D4, 2'd3);
    wait_ack(0, 1'b1, a0);
    chk("t1_ack_latency", 32'(a0 - c0), 5);
    chk("t1_writes", 32'(wr_cnt - base), 4);

    // Round-robin from reset, requesters drop after ack
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      post(i, 32'h10 + 32'(i), 2'd0);
      expect_word(i, 32'h10 + 32'(i), 2'd0);
    end
    for (int i = 0; i < NREQ; i++) begin
      wait_ack(i, 1'b1, a1);
      if (i > 0) chk("t2_ack_gap", 32'(a1 - a0), 3);
      a0 = a1;
    end

    // Requests held high: requeued under the arbitration policy
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) post(i, 32'h20 + 32'(i), 2'd0);
    for (int k = 0; k < 5; k++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
      id = 0;
`else
      id = k % NREQ;
`endif
      expect_word(id, 32'h20 + 32'(id), 2'd0);
    end
    for (int k = 0; k < 5; k++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
      wait_ack(0, 1'b0, a1);
`else
      wait_ack(k % NREQ, 1'b0, a1);
`endif
    end
    bus.req = '0;

    // Back-pressure after the first byte
    @(posedge clk); #1;
    c0 = cyc; base = wr_cnt;
    post(1, 32'h00005566, 2'd1);
    expect_word(1, 32'h00005566, 2'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    w0 = wr_cnt;
    chk("t3_first_byte", 32'(w0 - base), 1);
    bus.txff = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t3_stalled", 32'(wr_cnt - w0), 0);
    bus.txff = 1'b0;
    wait_ack(1, 1'b1, a0);
    chk("t3_ack_latency", 32'(a0 - c0), 8);
    chk("t3_total_writes", 32'(wr_cnt - base), 2);

    // Data and length change after the grant edge
    @(posedge clk); #1;
    c0 = cyc;
    post(2, 32'h11223344, 2'd3);
    expect_word(2, 32'h11223344, 2'd3);
    @(posedge clk); #1;
    bus.req_data[64 +: 32] = 32'hFFFFFFFF;
    bus.req_len[4 +: 2]    = 2'd0;
    wait_ack(2, 1'b1, a0);
    chk("t4_ack_latency", 32'(a0 - c0), 5);

    // Reset in the middle of a push
    @(posedge clk); #1;
    base = wr_cnt;
    post(0, 32'hDEADBEEF, 2'd3);
    expect_word(0, 32'hDEADBEEF, 2'd3);
    for (int i = 0; i < 20 && (wr_cnt - base) < 2; i++) begin
      @(posedge clk); #1;
    end
    chk("t5_two_bytes", 32'(wr_cnt - base), 2);
    reset   = 1'b0;
    bus.req = '0;
    exp_b.delete();
    exp_a.delete();
    #1;
    chk("t5_rst_fifo_wr", 32'(bus.fifo_wr), 0);
    chk("t5_rst_ack", 32'(bus.ack), 0);
    chk("t5_rst_busy", 32'(bus.busy), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    base = wr_cnt;
    post(1, 32'hCAFE0077, 2'd0);
    expect_word(1, 32'hCAFE0077, 2'd0);
    wait_ack(1, 1'b1, a0);
    chk("t5_writes_after", 32'(wr_cnt - base), 1);

    // Wrap: requester 3 first, then 0 and 2 arrive during its push
    do_reset();
    @(posedge clk); #1;
    post(3, 32'h03020100, 2'd3);
    expect_word(3, 32'h03020100, 2'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    post(0, 32'h000000A0, 2'd0);
    post(2, 32'h0000B2A2, 2'd1);
    expect_word(0, 32'h000000A0, 2'd0);
    expect_word(2, 32'h0000B2A2, 2'd1);
    wait_ack(3, 1'b1, a0);
    wait_ack(0, 1'b1, a0);
    wait_ack(2, 1'b1, a0);

    repeat (3) @(posedge clk);
    #1;
    chk("bytes_left", 32'(exp_b.size()), 0);
    chk("acks_left", 32'(exp_a.size()), 0);
    chk("idle_at_end", 32'(bus.busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmit path among NREQ requesters. Each requester posts a 32-bit word plus a byte count. The block grants one requester at a time, round-robin. It serialises the granted word LSB-byte-first into the TX FIFO write port (byte data plus new_data strobe) and honours FIFO-full back-pressure. It sits between software/peripheral sources and the TX FIFO feeding the UART TX controller/datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of grant-id output; must satisfy 2**IDW >= NREQ

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
req  input  NREQ  per-requester request; held high until ack seen
req_data  input  32*NREQ  requester i word at bits [32*i+31:32*i]
req_len  input  2*NREQ  requester i byte count minus 1 (0 = 1 byte, 3 = 4 bytes)
ack  output  NREQ  one-cycle pulse to the winner when its last byte is written
txff  input  1  TX FIFO full
fifo_wr  output  1  write strobe to TX FIFO (new_data)
fifo_wdata  output  8  byte to TX FIFO
busy  output  1  high in PUSH and DONE
gnt_id  output  IDW  index of current/last winner

Behaviour:
- Reset (reset=0, async): state=IDLE; ack=0, fifo_wr=0, fifo_wdata=0, busy=0, gnt_id=0; rr_ptr=NREQ-1, so requester 0 wins first. Reset mid-transfer abandons remaining bytes with no ack; bytes already written stay in the FIFO.
- FSM states: IDLE, PUSH, DONE.
- IDLE:
  - If req != 0, select the winner by round-robin: first set req bit searching from rr_ptr+1 upward, wrapping at NREQ-1 to 0.
  - At the next edge: latch req_data[winner] into shift_reg, req_len[winner] into byte_cnt, winner into gnt_id; state=PUSH.
  - If req == 0, remain in IDLE with no outputs active.
- PUSH:
  - fifo_wr = !txff (combinational from the registered state); fifo_wdata = shift_reg[7:0].
  - On an edge with fifo_wr=1: shift_reg >>= 8 (zero-fill). If byte_cnt==0, state=DONE; otherwise byte_cnt -= 1.
  - txff=1: hold shift_reg and byte_cnt; no write; no timeout.
- DONE (exactly one cycle): ack[gnt_id]=1, all other ack bits 0; rr_ptr=gnt_id; state=IDLE at the next edge.
- Latency with no back-pressure:
  - req rises in IDLE cycle N.
  - Bytes are written in cycles N+1 .. N+1+len.
  - ack is high in cycle N+2+len.
  - The next grant is evaluated in cycle N+3+len.
  - Back-to-back throughput: one word per len+3 cycles.
- Requester rules:
  - req_data/req_len are sampled only at the grant edge. Later changes, or dropping req during PUSH, do not affect the transfer, which completes and acks normally.
  - A requester must drop req in the cycle after ack (registered response) to avoid a regrant. If req stays high, it is re-queued normally under round-robin.
- Simultaneous events:
  - New req bits arriving during PUSH/DONE wait; they are not lost.
  - txff rising in the same cycle as the last byte: that byte is not written; DONE waits until txff drops.
  - Only one fifo_wr per cycle; fifo_wr is never asserted outside PUSH.
- Round-robin fairness: with all req high, grant order is 0,1,2,3,0,...; no requester waits more than NREQ-1 grants.

Optional Feature:
UART_ARB_FIXED_PRIO_EN:
- Defined: winner is the lowest-index set req bit; rr_ptr is not used or updated.
- Undefined: round-robin as above.
- All other timing is identical in both builds.

Test Plan:
- Single 4-byte: req[0]=1, data0=0xA1B2C3D4, len0=3, txff=0 -> fifo_wdata D4,C3,B2,A1 on 4 consecutive fifo_wr cycles starting 1 cycle after req; ack[0] pulses 1 cycle later; gnt_id=0.
- Round-robin: req=4'b1111, len=0 each, data i=0x10+i, requesters drop req after ack -> bytes 0x10,0x11,0x12,0x13 in order; each ack 3 cycles apart. With UART_ARB_FIXED_PRIO_EN and req held, only requester 0 is served.
- Back-pressure: 2-byte word 0x00005566, txff=1 for 5 cycles after the first byte -> 0x66, then no fifo_wr for 5 cycles, then 0x55, then ack; total writes=2.
- Data change after grant: change data0 to 0xFFFFFFFF one cycle after grant -> original bytes are still sent.
- Reset mid-PUSH: assert reset after 2 of 4 bytes -> fifo_wr, ack and busy go 0 immediately. After release, req[1] only -> requester 1 granted; no stale bytes sent.
- Wrap and simultaneous arrival: grant requester 3 (NREQ=4), raise req[0] and req[2] during its PUSH -> requester 0 is served next, then 2.
